// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// parity mode constants and counter-width helpers.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    // Bit-period counter width; one spare bit so the count never wraps inside a bit.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return $clog2(clks_per_bit) + 1;
    endfunction

    // Width of an index that must reach n-1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bus: received byte, qualifying flags and the valid/ready handshake.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_DV;
    logic                 i_Rx_Ready;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Overrun;
    logic                 o_Busy;

    modport master (
        output o_Rx_Byte, o_Rx_DV, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy,
        input  i_Rx_Ready
    );

    modport slave (
        input  o_Rx_Byte, o_Rx_DV, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy,
        output i_Rx_Ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Double-flop synchroniser for the serial line plus the bit-sample source.
// UART_RX_MAJORITY_EN defined: sample is a 2-of-3 vote over the last three synced values.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_serial,
    output logic rx_sync,
    output logic sample_c
);

    logic meta;

    // Idle-high line, so both stages reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            meta    <= rx_serial;
            rx_sync <= meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_sync};
        end
    end

    // Vote over the current and two previous synced values.
    assign sample_c = (rx_sync & hist[0]) | (rx_sync & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample_c = rx_sync;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
// with valid/ready output holding register. UART_RX_MAJORITY_EN selects 2-of-3 voted sampling.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Rx_Serial,
    uart_rx_param_if.master  rx
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IW = idx_width(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    // The vote completes one cycle after the window centre, so only the start decision moves.
    localparam int unsigned VOTE_LAG = 1;
`else
    localparam int unsigned VOTE_LAG = 0;
`endif
    localparam logic [CW-1:0] START_CNT = CW'(CLKS_PER_BIT / 2 + VOTE_LAG);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;
    logic                 frm_err;
    logic                 rx_sync;
    logic                 sample_c;
    logic                 bit_end_c;

    uart_rx_sampler u_sampler (
        .clk       (i_Clock),
        .rst_n     (i_Reset_n),
        .rx_serial (i_Rx_Serial),
        .rx_sync   (rx_sync),
        .sample_c  (sample_c)
    );

    assign bit_end_c = (cnt == BIT_END);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            stop_idx        <= 1'b0;
            shift           <= '0;
            par_err         <= 1'b0;
            frm_err         <= 1'b0;
            rx.o_Rx_Byte    <= '0;
            rx.o_Rx_DV      <= 1'b0;
            rx.o_Parity_Err <= 1'b0;
            rx.o_Frame_Err  <= 1'b0;
            rx.o_Overrun    <= 1'b0;
            rx.o_Busy       <= 1'b0;
        end else begin
            rx.o_Overrun <= 1'b0;
            if (rx.o_Rx_DV && rx.i_Rx_Ready) begin
                rx.o_Rx_DV <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                    par_err  <= 1'b0;
                    frm_err  <= 1'b0;
                    if (!rx_sync) begin
                        state     <= ST_START;
                        rx.o_Busy <= 1'b1;
                    end
                end

                // A start bit that is high again at its centre is treated as a glitch.
                ST_START: begin
                    if (cnt == START_CNT) begin
                        cnt <= '0;
                        if (sample_c) begin
                            state     <= ST_IDLE;
                            rx.o_Busy <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (bit_end_c) begin
                        cnt   <= '0;
                        shift <= {sample_c, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            if (PARITY_MODE != PARITY_NONE) begin
                                state <= ST_PARITY;
                            end else begin
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_PARITY: begin
                    if (bit_end_c) begin
                        cnt     <= '0;
                        par_err <= ((^shift) ^ sample_c) != (PARITY_MODE == PARITY_ODD);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // Frames are delivered even with errors; a still-pending byte turns the new one into an overrun.
                ST_STOP: begin
                    if (bit_end_c) begin
                        cnt <= '0;
                        if (stop_idx == LAST_STOP) begin
                            if (!rx.o_Rx_DV || rx.i_Rx_Ready) begin
                                rx.o_Rx_Byte    <= shift;
                                rx.o_Parity_Err <= par_err;
                                rx.o_Frame_Err  <= frm_err | ~sample_c;
                                rx.o_Rx_DV      <= 1'b1;
                            end else begin
                                rx.o_Overrun <= 1'b1;
                            end
                            if (sample_c) begin
                                state     <= ST_IDLE;
                                rx.o_Busy <= 1'b0;
                            end else begin
                                state <= ST_WAIT_HIGH;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            frm_err  <= frm_err | ~sample_c;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_WAIT_HIGH: begin
                    if (rx_sync) begin
                        state     <= ST_IDLE;
                        rx.o_Busy <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    rx.o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 7E1 and 8N2 instances driven from vector tables
// plus hand-written overrun, glitch, break and mid-frame reset sequences.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] line = 3'b111;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(7)) if_b ();
    uart_rx_param_if #(.DATA_BITS(8)) if_c ();

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(line[0]), .rx(if_a));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(line[1]), .rx(if_b));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) dut_c (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Rx_Serial(line[2]), .rx(if_c));

    int         total = 0;
    int         passed = 0;
    int         cap_cnt [3] = '{0, 0, 0};
    int         ovr_cnt [3] = '{0, 0, 0};
    logic [8:0] cap_byte[3] = '{9'd0, 9'd0, 9'd0};
    logic       cap_pe  [3] = '{1'b0, 1'b0, 1'b0};
    logic       cap_fe  [3] = '{1'b0, 1'b0, 1'b0};

    // Records every accepted byte (DV & ready) and every overrun pulse, mid-cycle.
    always @(negedge clk) begin
        if (if_a.o_Rx_DV && if_a.i_Rx_Ready) begin
            cap_cnt[0]++; cap_byte[0] = 9'(if_a.o_Rx_Byte);
            cap_pe[0] = if_a.o_Parity_Err; cap_fe[0] = if_a.o_Frame_Err;
        end
        if (if_b.o_Rx_DV && if_b.i_Rx_Ready) begin
            cap_cnt[1]++; cap_byte[1] = 9'(if_b.o_Rx_Byte);
            cap_pe[1] = if_b.o_Parity_Err; cap_fe[1] = if_b.o_Frame_Err;
        end
        if (if_c.o_Rx_DV && if_c.i_Rx_Ready) begin
            cap_cnt[2]++; cap_byte[2] = 9'(if_c.o_Rx_Byte);
            cap_pe[2] = if_c.o_Parity_Err; cap_fe[2] = if_c.o_Frame_Err;
        end
        if (if_a.o_Overrun) ovr_cnt[0]++;
        if (if_b.o_Overrun) ovr_cnt[1]++;
        if (if_c.o_Overrun) ovr_cnt[2]++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send(input int idx, input logic [8:0] data, input int nbits,
                        input bit par_en, input logic pbit, input int nstop,
                        input logic s1, input logic s2, input bit release_line);
        line[idx] = 1'b0;
        tick(CPB);
        for (int i = 0; i < nbits; i++) begin
            line[idx] = data[i];
            tick(CPB);
        end
        if (par_en) begin
            line[idx] = pbit;
            tick(CPB);
        end
        line[idx] = s1;
        tick(CPB);
        if (nstop == 2) begin
            line[idx] = s2;
            tick(CPB);
        end
        if (release_line) line[idx] = 1'b1;
    endtask

    typedef struct {
        logic [8:0] data;
        logic       stop;
        logic       exp_fe;
    } vec_a_t;

    typedef struct {
        logic [8:0] data;
        logic       pbit;
        logic       exp_pe;
    } vec_b_t;

    vec_a_t va[5];
    vec_b_t vb[5];
    int     prev;
    int     prev_ovr;

    initial begin
        va[0] = '{9'h0A5, 1'b1, 1'b0};
        va[1] = '{9'h000, 1'b1, 1'b0};
        va[2] = '{9'h0FF, 1'b1, 1'b0};
        va[3] = '{9'h03C, 1'b1, 1'b0};
        va[4] = '{9'h081, 1'b0, 1'b1};
        vb[0] = '{9'h041, 1'b1, 1'b1};
        vb[1] = '{9'h041, 1'b0, 1'b0};
        vb[2] = '{9'h07F, 1'b1, 1'b0};
        vb[3] = '{9'h07F, 1'b0, 1'b1};
        vb[4] = '{9'h02A, 1'b1, 1'b0};

        if_a.i_Rx_Ready = 1'b1;
        if_b.i_Rx_Ready = 1'b1;
        if_c.i_Rx_Ready = 1'b1;

        tick(3);
        chk("reset_dv",   32'(if_a.o_Rx_DV), 32'd0);
        chk("reset_byte", 32'(if_a.o_Rx_Byte), 32'd0);
        chk("reset_busy", 32'(if_a.o_Busy), 32'd0);
        chk("reset_ferr", 32'(if_a.o_Frame_Err), 32'd0);
        rst_n = 1'b1;
        tick(CPB);

        // 8N1 frames, last one with a low stop bit
        for (int i = 0; i < 5; i++) begin
            prev = cap_cnt[0];
            send(0, va[i].data, 8, 1'b0, 1'b0, 1, va[i].stop, 1'b1, 1'b1);
            tick(CPB);
            chk($sformatf("a%0d_cnt", i),  32'(cap_cnt[0]), 32'(prev + 1));
            chk($sformatf("a%0d_byte", i), 32'(cap_byte[0]), 32'(va[i].data));
            chk($sformatf("a%0d_perr", i), 32'(cap_pe[0]), 32'd0);
            chk($sformatf("a%0d_ferr", i), 32'(cap_fe[0]), 32'(va[i].exp_fe));
            chk($sformatf("a%0d_dv_low", i), 32'(if_a.o_Rx_DV), 32'd0);
        end

        // 7E1 parity frames
        for (int i = 0; i < 5; i++) begin
            prev = cap_cnt[1];
            send(1, vb[i].data, 7, 1'b1, vb[i].pbit, 1, 1'b1, 1'b1, 1'b1);
            tick(CPB);
            chk($sformatf("b%0d_cnt", i),  32'(cap_cnt[1]), 32'(prev + 1));
            chk($sformatf("b%0d_byte", i), 32'(cap_byte[1]), 32'(vb[i].data));
            chk($sformatf("b%0d_perr", i), 32'(cap_pe[1]), 32'(vb[i].exp_pe));
            chk($sformatf("b%0d_ferr", i), 32'(cap_fe[1]), 32'd0);
        end

        // 8N2: second stop low, line held low afterwards
        prev = cap_cnt[2];
        send(2, 9'h055, 8, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        tick(CPB);
        chk("c_brk_cnt",  32'(cap_cnt[2]), 32'(prev + 1));
        chk("c_brk_byte", 32'(cap_byte[2]), 32'h55);
        chk("c_brk_ferr", 32'(cap_fe[2]), 32'd1);
        tick(CPB * 30);
        chk("c_wait_busy", 32'(if_c.o_Busy), 32'd1);
        chk("c_wait_cnt",  32'(cap_cnt[2]), 32'(prev + 1));
        line[2] = 1'b1;
        tick(CPB);
        chk("c_idle_busy", 32'(if_c.o_Busy), 32'd0);
        send(2, 9'h096, 8, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b1);
        tick(CPB);
        chk("c_ok_cnt",  32'(cap_cnt[2]), 32'(prev + 2));
        chk("c_ok_byte", 32'(cap_byte[2]), 32'h96);
        chk("c_ok_ferr", 32'(cap_fe[2]), 32'd0);

        // Overrun: consumer stalled across two frames
        if_a.i_Rx_Ready = 1'b0;
        prev = cap_cnt[0];
        prev_ovr = ovr_cnt[0];
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        tick(CPB);
        chk("ovr_dv1",   32'(if_a.o_Rx_DV), 32'd1);
        send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        tick(CPB);
        chk("ovr_dv2",   32'(if_a.o_Rx_DV), 32'd1);
        chk("ovr_byte",  32'(if_a.o_Rx_Byte), 32'h11);
        chk("ovr_pulse", 32'(ovr_cnt[0]), 32'(prev_ovr + 1));
        if_a.i_Rx_Ready = 1'b1;
        tick(1);
        chk("ovr_dv_drop",  32'(if_a.o_Rx_DV), 32'd0);
        chk("ovr_acc_byte", 32'(cap_byte[0]), 32'h11);
        chk("ovr_acc_cnt",  32'(cap_cnt[0]), 32'(prev + 1));

        // Six-cycle low glitch on an idle line
        prev = cap_cnt[0];
        line[0] = 1'b0;
        tick(6);
        line[0] = 1'b1;
        tick(3);
        chk("glitch_busy_start", 32'(if_a.o_Busy), 32'd1);
        tick(40);
        chk("glitch_busy_idle", 32'(if_a.o_Busy), 32'd0);
        chk("glitch_no_byte",   32'(cap_cnt[0]), 32'(prev));
        chk("glitch_dv",        32'(if_a.o_Rx_DV), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high spike inside the vote window of data bit 2
        prev = cap_cnt[0];
        line[0] = 1'b0;
        tick(CPB);
        tick(CPB * 2);
        tick(9);
        line[0] = 1'b1;
        tick(1);
        line[0] = 1'b0;
        tick(CPB - 10);
        tick(CPB * 5);
        line[0] = 1'b1;
        tick(CPB * 2);
        chk("spike_cnt",  32'(cap_cnt[0]), 32'(prev + 1));
        chk("spike_byte", 32'(cap_byte[0]), 32'h00);
`endif

        // Reset in the middle of data bit 3 with a byte still held
        if_a.i_Rx_Ready = 1'b0;
        send(0, 9'h077, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        tick(CPB);
        chk("rst_pre_dv", 32'(if_a.o_Rx_DV), 32'd1);
        line[0] = 1'b0;
        tick(CPB);
        line[0] = 1'b1;
        tick(CPB * 3);
        tick(8);
        chk("rst_pre_busy", 32'(if_a.o_Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dv",   32'(if_a.o_Rx_DV), 32'd0);
        chk("rst_mid_byte", 32'(if_a.o_Rx_Byte), 32'd0);
        chk("rst_mid_busy", 32'(if_a.o_Busy), 32'd0);
        tick(4);
        rst_n = 1'b1;
        if_a.i_Rx_Ready = 1'b1;
        tick(CPB * 2);
        prev = cap_cnt[0];
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        tick(CPB);
        chk("post_rst_cnt",  32'(cap_cnt[0]), 32'(prev + 1));
        chk("post_rst_byte", 32'(cap_byte[0]), 32'h3C);
        chk("post_rst_ferr", 32'(cap_fe[0]), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
